lcd_refresh_driver: RTL and testbench

Reads the 32-character display image from the combinational message ROM (raddr in, 8-bit char out) and drives a 16x2 HD44780-compatible character LCD on the DE2 header. After reset it runs the controller power-up/init sequence, then writes line 1 (ROM addresses 0-15) and line 2 (16-31). Afterwards it idles until `refresh` requests another pass, for example when the mode switches change.

---
 rtl/lcd_pkg.sv | 39 +++
 rtl/lcd_byte_writer.sv | 84 ++++++++
 rtl/lcd_refresh_driver.sv | 217 +++++++++++++++++++++
 tb/tb_lcd_refresh_driver.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_pkg.sv
// Shared definitions for the HD44780 refresh driver: command bytes, FSM state encodings
// and the init-command lookup used by the top-level sequencer.
package lcd_pkg;

   localparam logic [7:0] LCD_FUNC_SET = 8'h38;
   localparam logic [7:0] LCD_DISP_ON  = 8'h0C;
   localparam logic [7:0] LCD_CLEAR    = 8'h01;
   localparam logic [7:0] LCD_ENTRY    = 8'h06;
   localparam logic [7:0] LCD_LINE1    = 8'h80;
   localparam logic [7:0] LCD_LINE2    = 8'hC0;

   typedef enum logic [2:0] {
      ST_PWR_WAIT,
      ST_INIT,
      ST_LINE1_ADDR,
      ST_LINE1,
      ST_LINE2_ADDR,
      ST_LINE2,
      ST_DONE,
      ST_IDLE
   } lcd_state_t;

   typedef enum logic [1:0] {
      PH_IDLE,
      PH_SETUP,
      PH_EN_HI,
      PH_WAIT
   } byte_phase_t;

   function automatic logic [7:0] initCmd(input logic [1:0] idx);
      case (idx)
         2'd0:    return LCD_FUNC_SET;
         2'd1:    return LCD_DISP_ON;
         2'd2:    return LCD_CLEAR;
         default: return LCD_ENTRY;
      endcase
   endfunction

endpackage

// File: rtl/lcd_byte_writer.sv
// Drives one LCD byte as SETUP / EN_HI / WAIT; data and RS are held from SETUP to the end of WAIT.
// Characters are latched from i_byte at the end of SETUP so the ROM has that cycle to settle.
module lcd_byte_writer
   import lcd_pkg::*;
#(
   parameter int EN_CYCLES  = 25,
   parameter int CMD_CYCLES = 2_500,
   parameter int CLR_CYCLES = 100_000,
   parameter int CNT_W      = 17
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       i_start,
   input  logic [7:0] i_byte,
   input  logic       i_rs,
   output logic [7:0] o_lcd_data,
   output logic       o_lcd_rs,
   output logic       o_lcd_en,
   output logic       o_done
);

   byte_phase_t      r_phase;
   logic [CNT_W-1:0] r_cnt;
   logic [7:0]       r_data;
   logic             r_rs;
   logic             r_en;
   logic             r_isClear;

   logic             w_ready;
   logic [7:0]       w_setupData;

   assign o_done      = (r_phase == PH_WAIT) && (r_cnt == '0);
   assign w_ready     = (r_phase == PH_IDLE) || o_done;
   assign w_setupData = r_rs ? i_byte : r_data;

   // A new start is accepted in the last WAIT cycle so consecutive bytes run back to back.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_phase   <= PH_IDLE;
         r_cnt     <= '0;
         r_data    <= 8'h00;
         r_rs      <= 1'b0;
         r_en      <= 1'b0;
         r_isClear <= 1'b0;
      end else begin
         case (r_phase)
            PH_SETUP: begin
               r_data    <= w_setupData;
               r_isClear <= (w_setupData == LCD_CLEAR);
               r_en      <= 1'b1;
               r_cnt     <= CNT_W'(EN_CYCLES - 1);
               r_phase   <= PH_EN_HI;
            end
            PH_EN_HI: begin
               if (r_cnt == '0) begin
                  r_en    <= 1'b0;
                  r_cnt   <= r_isClear ? CNT_W'(CLR_CYCLES - 1) : CNT_W'(CMD_CYCLES - 1);
                  r_phase <= PH_WAIT;
               end else begin
                  r_cnt <= r_cnt - 1'b1;
               end
            end
            default: begin
               if (!w_ready) begin
                  r_cnt <= r_cnt - 1'b1;
               end else if (i_start) begin
                  r_phase <= PH_SETUP;
                  r_rs    <= i_rs;
                  if (!i_rs) begin
                     r_data <= i_byte;
                  end
               end else begin
                  r_phase <= PH_IDLE;
               end
            end
         endcase
      end
   end

   assign o_lcd_data = r_data;
   assign o_lcd_rs   = r_rs;
   assign o_lcd_en   = r_en;

endmodule

// File: rtl/lcd_refresh_driver.sv
// Sequences power-up wait, controller init and the two 16-character lines of a 16x2 LCD,
// reading characters from a combinational message ROM; refresh requests re-run the line writes.
module lcd_refresh_driver
   import lcd_pkg::*;
#(
   parameter int CLK_HZ     = 50_000_000,
   parameter int PWR_CYCLES = 750_000,
   parameter int EN_CYCLES  = 25,
   parameter int CMD_CYCLES = 2_500,
   parameter int CLR_CYCLES = 100_000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       refresh,
   input  logic [7:0] din,
   output logic [4:0] raddr,
   output logic [7:0] LCD_DATA,
   output logic       LCD_RS,
   output logic       LCD_RW,
   output logic       LCD_EN,
   output logic       LCD_ON,
   output logic       busy,
   output logic       frame_done
);

   localparam int MAX_WAIT = (PWR_CYCLES > CLR_CYCLES) ? PWR_CYCLES : CLR_CYCLES;
   localparam int CNT_W    = $clog2(MAX_WAIT + 1);

   lcd_state_t       r_state;
   logic [CNT_W-1:0] r_pwrCnt;
   logic [4:0]       r_idx;
   logic [4:0]       r_raddr;
   logic             r_pending;
   logic             r_busy;
   logic             r_frameDone;

   logic             w_start;
   logic             w_rs;
   logic [7:0]       w_cmd;
   logic [7:0]       w_byte;
   logic             w_done;
   logic             w_goRefresh;

   assign w_goRefresh = refresh | r_pending;
   assign w_byte      = (w_start && !w_rs) ? w_cmd : din;

   // Decide which byte (if any) to launch this cycle; launches coincide with state changes.
   always_comb begin
      w_start = 1'b0;
      w_rs    = 1'b0;
      w_cmd   = 8'h00;
      case (r_state)
         ST_PWR_WAIT: begin
            if (r_pwrCnt == '0) begin
               w_start = 1'b1;
               w_cmd   = LCD_FUNC_SET;
            end
         end
         ST_INIT: begin
            if (w_done) begin
               w_start = 1'b1;
               w_cmd   = (r_idx[1:0] == 2'd3) ? LCD_LINE1 : initCmd(r_idx[1:0] + 2'd1);
            end
         end
         ST_LINE1_ADDR, ST_LINE2_ADDR: begin
            if (w_done) begin
               w_start = 1'b1;
               w_rs    = 1'b1;
            end
         end
         ST_LINE1: begin
            if (w_done) begin
               w_start = 1'b1;
               if (r_idx == 5'd15) begin
                  w_cmd = LCD_LINE2;
               end else begin
                  w_rs = 1'b1;
               end
            end
         end
         ST_LINE2: begin
            if (w_done && (r_idx != 5'd31)) begin
               w_start = 1'b1;
               w_rs    = 1'b1;
            end
         end
         ST_DONE, ST_IDLE: begin
            if (w_goRefresh) begin
               w_start = 1'b1;
               w_cmd   = LCD_LINE1;
            end
         end
         default: begin
            w_start = 1'b0;
         end
      endcase
   end

   // busy drops on entry to DONE unless a refresh is already queued, so back-to-back passes stay busy.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state     <= ST_PWR_WAIT;
         r_pwrCnt    <= CNT_W'(PWR_CYCLES - 1);
         r_idx       <= 5'd0;
         r_raddr     <= 5'd0;
         r_pending   <= 1'b0;
         r_busy      <= 1'b1;
         r_frameDone <= 1'b0;
      end else begin
         r_frameDone <= 1'b0;
         if (refresh && r_busy) begin
            r_pending <= 1'b1;
         end
         case (r_state)
            ST_PWR_WAIT: begin
               if (r_pwrCnt == '0) begin
                  r_state <= ST_INIT;
                  r_idx   <= 5'd0;
               end else begin
                  r_pwrCnt <= r_pwrCnt - 1'b1;
               end
            end
            ST_INIT: begin
               if (w_done) begin
                  if (r_idx[1:0] == 2'd3) begin
                     r_state <= ST_LINE1_ADDR;
                     r_idx   <= 5'd0;
                  end else begin
                     r_idx <= r_idx + 5'd1;
                  end
               end
            end
            ST_LINE1_ADDR: begin
               if (w_done) begin
                  r_state <= ST_LINE1;
                  r_idx   <= 5'd0;
                  r_raddr <= 5'd0;
               end
            end
            ST_LINE1: begin
               if (w_done) begin
                  if (r_idx == 5'd15) begin
                     r_state <= ST_LINE2_ADDR;
                     r_raddr <= 5'd0;
                  end else begin
                     r_idx   <= r_idx + 5'd1;
                     r_raddr <= r_idx + 5'd1;
                  end
               end
            end
            ST_LINE2_ADDR: begin
               if (w_done) begin
                  r_state <= ST_LINE2;
                  r_idx   <= 5'd16;
                  r_raddr <= 5'd16;
               end
            end
            ST_LINE2: begin
               if (w_done) begin
                  if (r_idx == 5'd31) begin
                     r_state     <= ST_DONE;
                     r_raddr     <= 5'd0;
                     r_frameDone <= 1'b1;
                     r_busy      <= r_pending | refresh;
                  end else begin
                     r_idx   <= r_idx + 5'd1;
                     r_raddr <= r_idx + 5'd1;
                  end
               end
            end
            ST_DONE: begin
               r_pending <= 1'b0;
               if (w_goRefresh) begin
                  r_state <= ST_LINE1_ADDR;
                  r_busy  <= 1'b1;
               end else begin
                  r_state <= ST_IDLE;
               end
            end
            ST_IDLE: begin
               if (w_goRefresh) begin
                  r_state <= ST_LINE1_ADDR;
                  r_busy  <= 1'b1;
               end
            end
            default: begin
               r_state <= ST_PWR_WAIT;
            end
         endcase
      end
   end

   lcd_byte_writer #(
      .EN_CYCLES  (EN_CYCLES),
      .CMD_CYCLES (CMD_CYCLES),
      .CLR_CYCLES (CLR_CYCLES),
      .CNT_W      (CNT_W)
   ) u_byteWriter (
      .clk        (clk),
      .reset      (reset),
      .i_start    (w_start),
      .i_byte     (w_byte),
      .i_rs       (w_rs),
      .o_lcd_data (LCD_DATA),
      .o_lcd_rs   (LCD_RS),
      .o_lcd_en   (LCD_EN),
      .o_done     (w_done)
   );

   // Panel power is always on; CLK_HZ only documents the frequency the cycle defaults assume.
   assign LCD_ON     = (CLK_HZ > 0);
   assign LCD_RW     = 1'b0;
   assign raddr      = r_raddr;
   assign busy       = r_busy;
   assign frame_done = r_frameDone;

endmodule

// File: tb/tb_lcd_refresh_driver.sv
// Directed bench for lcd_refresh_driver with short timing parameters and a ROM returning 0x40+raddr.
module tb_lcd_refresh_driver;

   localparam int PWR         = 20;
   localparam int EN          = 3;
   localparam int CMD         = 5;
   localparam int CLR         = 12;
   localparam int PASS_CYCLES = 34 * (1 + EN + CMD);

   logic       clk = 1'b0;
   logic       reset;
   logic       refresh;
   logic [7:0] din;
   logic [4:0] raddr;
   logic [7:0] LCD_DATA;
   logic       LCD_RS;
   logic       LCD_RW;
   logic       LCD_EN;
   logic       LCD_ON;
   logic       busy;
   logic       frame_done;

   int romMode = 0;
   int cyc = 0;
   int checkCount = 0;
   int passCount = 0;
   int failCount = 0;

   logic [7:0] d;
   logic       r;
   logic [4:0] a;
   int         lo, hi, n, startCyc;
   int         dones, firstDone, secondDone;
   logic       busyAtFirst, busyAtSecond, busyAfterFirst;
   logic [7:0] dataAfterFirst;

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   function automatic logic [7:0] romChar(input int mode, input logic [4:0] addr);
      logic [7:0] c;
      c = 8'h40 + {3'b000, addr};
      if (mode == 1) begin
         case (addr)
            5'd16: c = "E";
            5'd17: c = "a";
            5'd18: c = "s";
            5'd19: c = "y";
            default: ;
         endcase
      end else if (mode == 2) begin
         case (addr)
            5'd16: c = "H";
            5'd17: c = "a";
            5'd18: c = "r";
            5'd19: c = "d";
            default: ;
         endcase
      end
      return c;
   endfunction

   always_comb din = romChar(romMode, raddr);

   lcd_refresh_driver #(
      .CLK_HZ     (50_000_000),
      .PWR_CYCLES (PWR),
      .EN_CYCLES  (EN),
      .CMD_CYCLES (CMD),
      .CLR_CYCLES (CLR)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .refresh    (refresh),
      .din        (din),
      .raddr      (raddr),
      .LCD_DATA   (LCD_DATA),
      .LCD_RS     (LCD_RS),
      .LCD_RW     (LCD_RW),
      .LCD_EN     (LCD_EN),
      .LCD_ON     (LCD_ON),
      .busy       (busy),
      .frame_done (frame_done)
   );

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checkCount++;
      assert (observed === expected) passCount++;
      else begin
         failCount++;
         $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input logic rstVal, input logic refVal);
      reset   = rstVal;
      refresh = refVal;
   endtask

   task automatic pulseRefresh();
      applyStimulus(1'b0, 1'b1);
      @(negedge clk);
      applyStimulus(1'b0, 1'b0);
   endtask

   // Called at a negedge: counts low samples up to the EN pulse, captures the bus, counts high samples.
   task automatic nextByte(output logic [7:0] data, output logic rs, output logic [4:0] addr,
                           output int lowLen, output int hiLen);
      lowLen = 0;
      hiLen  = 0;
      while (LCD_EN !== 1'b1 && lowLen < 400) begin
         lowLen++;
         @(negedge clk);
      end
      data = LCD_DATA;
      rs   = LCD_RS;
      addr = raddr;
      while (LCD_EN === 1'b1 && hiLen < 50) begin
         hiLen++;
         @(negedge clk);
      end
   endtask

   task automatic waitFrameDone(output int cycles);
      cycles = 0;
      while (frame_done !== 1'b1 && cycles < 700) begin
         @(negedge clk);
         cycles++;
      end
   endtask

   task automatic checkInitSequence(input string pfx);
      logic [7:0] cmds [5];
      int         gaps [5];
      cmds = '{8'h38, 8'h0C, 8'h01, 8'h06, 8'h80};
      gaps = '{PWR + 1, CMD + 1, CMD + 1, CLR + 1, CMD + 1};
      for (int i = 0; i < 5; i++) begin
         nextByte(d, r, a, lo, hi);
         checkOutput($sformatf("%s cmd%0d data", pfx, i), {24'h0, d}, {24'h0, cmds[i]});
         checkOutput($sformatf("%s cmd%0d rs", pfx, i), {31'h0, r}, 32'd0);
         checkOutput($sformatf("%s cmd%0d en_len", pfx, i), hi, EN);
         checkOutput($sformatf("%s cmd%0d low_len", pfx, i), lo, gaps[i]);
      end
   endtask

   task automatic checkLine(input int firstAddr);
      for (int i = 0; i < 16; i++) begin
         nextByte(d, r, a, lo, hi);
         checkOutput($sformatf("char%0d data", firstAddr + i), {24'h0, d}, 32'h40 + firstAddr + i);
         checkOutput($sformatf("char%0d rs", firstAddr + i), {31'h0, r}, 32'd1);
         checkOutput($sformatf("char%0d raddr", firstAddr + i), {27'h0, a}, firstAddr + i);
         checkOutput($sformatf("char%0d low_len", firstAddr + i), lo, CMD + 1);
      end
   endtask

   task automatic checkWord(input string tag, input logic [31:0] word);
      pulseRefresh();
      for (int i = 0; i < 18; i++) begin
         nextByte(d, r, a, lo, hi);
      end
      for (int i = 0; i < 4; i++) begin
         nextByte(d, r, a, lo, hi);
         checkOutput($sformatf("%s char%0d", tag, 16 + i), {24'h0, d}, {24'h0, word[8*(3-i) +: 8]});
         checkOutput($sformatf("%s raddr%0d", tag, 16 + i), {27'h0, a}, 16 + i);
      end
      waitFrameDone(n);
      checkOutput($sformatf("%s frame_done", tag), {31'h0, frame_done}, 32'd1);
      @(negedge clk);
   endtask

   initial begin
      applyStimulus(1'b1, 1'b0);
      @(negedge clk);
      @(negedge clk);
      checkOutput("reset LCD_EN", {31'h0, LCD_EN}, 32'd0);
      checkOutput("reset LCD_ON", {31'h0, LCD_ON}, 32'd1);
      checkOutput("reset busy", {31'h0, busy}, 32'd1);
      checkOutput("reset raddr", {27'h0, raddr}, 32'd0);
      checkOutput("reset LCD_DATA", {24'h0, LCD_DATA}, 32'd0);
      checkOutput("reset LCD_RS", {31'h0, LCD_RS}, 32'd0);
      checkOutput("reset LCD_RW", {31'h0, LCD_RW}, 32'd0);
      checkOutput("reset frame_done", {31'h0, frame_done}, 32'd0);

      // Power-up, init commands and the first full pass
      applyStimulus(1'b0, 1'b0);
      checkInitSequence("init");
      checkLine(0);
      nextByte(d, r, a, lo, hi);
      checkOutput("line2 cmd data", {24'h0, d}, 32'hC0);
      checkOutput("line2 cmd rs", {31'h0, r}, 32'd0);
      checkOutput("line2 cmd low_len", lo, CMD + 1);
      checkLine(16);
      waitFrameDone(n);
      checkOutput("pass1 done delay", n, CMD);
      checkOutput("pass1 busy at done", {31'h0, busy}, 32'd0);
      checkOutput("pass1 raddr at done", {27'h0, raddr}, 32'd0);
      @(negedge clk);
      checkOutput("pass1 done one cycle", {31'h0, frame_done}, 32'd0);
      checkOutput("idle busy", {31'h0, busy}, 32'd0);
      checkOutput("idle LCD_RW", {31'h0, LCD_RW}, 32'd0);

      // Refresh from IDLE: 0x80 SETUP on the next cycle, no init bytes
      pulseRefresh();
      startCyc = cyc;
      checkOutput("refresh setup data", {24'h0, LCD_DATA}, 32'h80);
      checkOutput("refresh setup rs", {31'h0, LCD_RS}, 32'd0);
      checkOutput("refresh setup en", {31'h0, LCD_EN}, 32'd0);
      checkOutput("refresh busy", {31'h0, busy}, 32'd1);
      nextByte(d, r, a, lo, hi);
      checkOutput("refresh first byte", {24'h0, d}, 32'h80);
      checkOutput("refresh first low_len", lo, 1);
      waitFrameDone(n);
      checkOutput("refresh pass length", cyc - startCyc, PASS_CYCLES);
      @(negedge clk);

      // Three coalescing refreshes during a pass
      pulseRefresh();
      dones = 0;
      firstDone = -1;
      secondDone = -1;
      busyAtFirst = 1'b0;
      busyAtSecond = 1'b1;
      busyAfterFirst = 1'b0;
      dataAfterFirst = 8'h00;
      for (int k = 0; k < 650; k++) begin
         applyStimulus(1'b0, (k == 20 || k == 50 || k == 170));
         if (firstDone >= 0 && k == firstDone + 1) begin
            dataAfterFirst = LCD_DATA;
            busyAfterFirst = busy;
         end
         if (frame_done === 1'b1) begin
            dones++;
            if (dones == 1) begin
               firstDone = k;
               busyAtFirst = busy;
            end else if (dones == 2) begin
               secondDone = k;
               busyAtSecond = busy;
            end
         end
         @(negedge clk);
      end
      applyStimulus(1'b0, 1'b0);
      checkOutput("coalesce done count", dones, 2);
      checkOutput("coalesce first done", firstDone, PASS_CYCLES);
      checkOutput("coalesce second done", secondDone, 2 * PASS_CYCLES + 1);
      checkOutput("coalesce busy at first", {31'h0, busyAtFirst}, 32'd1);
      checkOutput("coalesce busy after first", {31'h0, busyAfterFirst}, 32'd1);
      checkOutput("coalesce 0x80 after first", {24'h0, dataAfterFirst}, 32'h80);
      checkOutput("coalesce busy at second", {31'h0, busyAtSecond}, 32'd0);

      // Reset during EN_HI of char 7
      pulseRefresh();
      for (int i = 0; i < 8; i++) begin
         nextByte(d, r, a, lo, hi);
      end
      n = 0;
      while (LCD_EN !== 1'b1 && n < 100) begin
         @(negedge clk);
         n++;
      end
      checkOutput("char7 raddr before reset", {27'h0, raddr}, 32'd7);
      checkOutput("char7 data before reset", {24'h0, LCD_DATA}, 32'h47);
      applyStimulus(1'b1, 1'b0);
      #1;
      checkOutput("abort LCD_EN", {31'h0, LCD_EN}, 32'd0);
      checkOutput("abort raddr", {27'h0, raddr}, 32'd0);
      checkOutput("abort busy", {31'h0, busy}, 32'd1);
      @(negedge clk);
      applyStimulus(1'b0, 1'b0);
      checkInitSequence("reinit");
      waitFrameDone(n);
      checkOutput("reinit frame_done", {31'h0, frame_done}, 32'd1);
      @(negedge clk);

      // Message image switched between passes
      romMode = 1;
      checkWord("easy", "Easy");
      romMode = 2;
      checkWord("hard", "Hard");

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
